// File: rtl/weight_dot_accumulator.sv
// weight_dot_accumulator: joins activation and weight beats, sums lane products over IN_DEPTH beats
//   clk, rst (async, active-high)
//   data_in_0[PARALLELISM] / data_in_0_valid / data_in_0_ready : activation stream
//   weight[PARALLELISM]    / weight_valid    / weight_ready    : weight stream
//   data_out_0 / data_out_0_valid / data_out_0_ready           : full-precision dot product
//   Output fractional bits = DATA_IN_0_PRECISION_1 + WEIGHT_PRECISION_1 (no rounding applied).
module weight_dot_accumulator #(
  parameter int DATA_IN_0_PRECISION_0 = 16,
  parameter int DATA_IN_0_PRECISION_1 = 3,
  parameter int WEIGHT_PRECISION_0    = 16,
  parameter int WEIGHT_PRECISION_1    = 3,
  parameter int PARALLELISM           = 4,
  parameter int TENSOR_SIZE_DIM_0     = 16,
  parameter int IN_DEPTH              = TENSOR_SIZE_DIM_0 / PARALLELISM,
  parameter int ACC_WIDTH             = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 +
                                        $clog2(PARALLELISM) + $clog2(IN_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [PARALLELISM],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic [WEIGHT_PRECISION_0-1:0]    weight [PARALLELISM],
  input  logic                             weight_valid,
  output logic                             weight_ready,
  output logic [ACC_WIDTH-1:0]             data_out_0,
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
);
  localparam int PW = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0;
  localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] OUTPUT = 1'b1;
  logic [0:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, out_q, out_d;
  logic                        vld_q, vld_d;
  logic signed [PW-1:0]        prod [PARALLELISM];
  logic signed [ACC_WIDTH-1:0] lane_sum, sum;
  logic                        can_take, fire, last, consume;
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      prod[i]  = PW'($signed(data_in_0[i])) * PW'($signed(weight[i]));
      lane_sum = lane_sum + ACC_WIDTH'(prod[i]);
    end
  end
  // A held result blocks intake until downstream takes it; readies stay low in reset.
  assign can_take        = !rst && (state_q == ACCUM || data_out_0_ready);
  assign data_in_0_ready = can_take && weight_valid;
  assign weight_ready    = can_take && data_in_0_valid;
  assign fire            = can_take && data_in_0_valid && weight_valid;
  assign last            = cnt_q == CW'(IN_DEPTH - 1);
  assign consume         = state_q == OUTPUT && data_out_0_ready;
  // Beat 0 (or any beat arriving while a result is drained) starts a fresh sum.
  assign sum             = (cnt_q == '0 || state_q == OUTPUT) ? lane_sum : acc_q + lane_sum;
  always_comb begin
    acc_d   = fire ? sum : acc_q;
    cnt_d   = fire ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    out_d   = (fire && last) ? sum : out_q;
    vld_d   = (fire && last) ? 1'b1 : (consume ? 1'b0 : vld_q);
    state_d = (fire && last) ? OUTPUT : (consume ? ACCUM : state_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end
  assign data_out_0       = out_q;
  assign data_out_0_valid = vld_q;
endmodule

// File: tb/tb_weight_dot_accumulator.sv
// tb_weight_dot_accumulator: directed scoreboard bench for weight_dot_accumulator
module tb_weight_dot_accumulator;
  localparam int P  = 4;
  localparam int AW = 36;
  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   act [P];
  logic [15:0]   wt  [P];
  logic          act_v, wt_v, act_r, wt_r;
  logic [AW-1:0] dout;
  logic          dout_v, dout_r;
  longint        sb [$];
  int            checks = 0;
  int            errors = 0;
  int            outs   = 0;
  weight_dot_accumulator dut (
    .clk(clk), .rst(rst),
    .data_in_0(act), .data_in_0_valid(act_v), .data_in_0_ready(act_r),
    .weight(wt), .weight_valid(wt_v), .weight_ready(wt_r),
    .data_out_0(dout), .data_out_0_valid(dout_v), .data_out_0_ready(dout_r)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_in(input int a, input int w, input logic av, input logic wv);
    for (int i = 0; i < P; i++) begin
      act[i] = 16'(a);
      wt[i]  = 16'(w);
    end
    act_v = av;
    wt_v  = wv;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (!rst && dout_v && dout_r) begin
      outs++;
      if (sb.size() == 0) chk("unexpected_result", longint'($signed(dout)), -1);
      else chk("result", longint'($signed(dout)), sb.pop_front());
    end
  end
  initial begin
    rst    = 1'b1;
    dout_r = 1'b1;
    set_in(1, 2, 1'b1, 1'b1);
    #3;
    chk("rst_valid", longint'(dout_v), 0);
    chk("rst_data", longint'(dout), 0);
    chk("rst_act_ready", longint'(act_r), 0);
    chk("rst_wt_ready", longint'(wt_r), 0);
    set_in(0, 0, 1'b0, 1'b0);
    #19 rst = 1'b0;
    step();
    // 1 x 2 over 16 elements -> 32, valid exactly one cycle after 4th fire
    sb.push_back(32);
    set_in(1, 2, 1'b1, 1'b1);
    repeat (3) step();
    chk("t1_not_early", longint'(dout_v), 0);
    step();
    set_in(0, 0, 1'b0, 1'b0);
    chk("t1_valid_rise", longint'(dout_v), 1);
    chk("t1_data", longint'($signed(dout)), 32);
    step();
    chk("t1_valid_drop", longint'(dout_v), 0);
    // Back-to-back: negative, then extreme magnitudes, no bubble between results
    sb.push_back(-240);
    sb.push_back(64'sd17179869184);
    sb.push_back(-64'sd17179344896);
    for (int j = 1; j <= 12; j++) begin
      if (j <= 4) set_in(-3, 5, 1'b1, 1'b1);
      else if (j <= 8) set_in(-32768, -32768, 1'b1, 1'b1);
      else set_in(-32768, 32767, 1'b1, 1'b1);
      step();
      chk($sformatf("b2b_valid_%0d", j), longint'(dout_v), (j % 4 == 0) ? 1 : 0);
    end
    set_in(0, 0, 1'b0, 1'b0);
    step();
    // Backpressure: result held, readies low, then release fires immediately
    sb.push_back(16);
    dout_r = 1'b0;
    set_in(1, 1, 1'b1, 1'b1);
    repeat (4) step();
    set_in(2, 1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", longint'(dout_v), 1);
      chk("bp_data", longint'($signed(dout)), 16);
      chk("bp_act_ready", longint'(act_r), 0);
      chk("bp_wt_ready", longint'(wt_r), 0);
      step();
    end
    sb.push_back(32);
    dout_r = 1'b1;
    #1;
    chk("bp_release_ready", longint'(act_r), 1);
    repeat (4) step();
    set_in(0, 0, 1'b0, 1'b0);
    step();
    // Join: weight valid held, activation valid toggles
    sb.push_back(40);
    for (int k = 1; k <= 4; k++) begin
      set_in(k, 1, 1'b1, 1'b1);
      #1;
      chk("join_wt_ready_hi", longint'(wt_r), 1);
      step();
      set_in(k, 1, 1'b0, 1'b1);
      #1;
      chk("join_wt_ready_lo", longint'(wt_r), 0);
      chk("join_act_ready", longint'(act_r), 1);
      step();
    end
    set_in(0, 0, 1'b0, 1'b0);
    step();
    // Async reset mid-accumulation discards the partial sum
    set_in(1, 1, 1'b1, 1'b1);
    repeat (2) step();
    set_in(0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    sb.push_back(16);
    set_in(1, 1, 1'b1, 1'b1);
    repeat (4) step();
    set_in(0, 0, 1'b0, 1'b0);
    repeat (3) step();
    chk("sb_drained", longint'(sb.size()), 0);
    chk("result_count", longint'(outs), 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_dot_accumulator.md
Name: weight_dot_accumulator

Overview:
- Downstream consumer of a per-layer weight source stream, e.g. the encoder layer-2 intermediate dense weights.
- Joins the activation stream with the weight stream, multiplies lane-wise in signed fixed point, and sums the products across lanes.
- Accumulates over IN_DEPTH beats and emits one full-precision dot-product vector per output.
- Sits inside the linear-layer datapath, between the weight/activation sources and the bias/cast stage.

Parameters:
- DATA_IN_0_PRECISION_0, 16: activation word width (signed).
- DATA_IN_0_PRECISION_1, 3: activation fractional bits.
- WEIGHT_PRECISION_0, 16: weight word width (signed).
- WEIGHT_PRECISION_1, 3: weight fractional bits.
- PARALLELISM, 4: lanes per beat. Must match the weight source's WEIGHT_PARALLELISM_DIM_0*DIM_1.
- TENSOR_SIZE_DIM_0, 16: elements per dot product. Must be a multiple of PARALLELISM.
- IN_DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM: beats per dot product. Must be at least 1.
- ACC_WIDTH, DATA_IN_0_PRECISION_0+WEIGHT_PRECISION_0+$clog2(PARALLELISM)+$clog2(IN_DEPTH): output width.
- Output fractional bits are DATA_IN_0_PRECISION_1+WEIGHT_PRECISION_1 (informational, no rounding).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- data_in_0, input, [DATA_IN_0_PRECISION_0-1:0] x PARALLELISM: activation lanes.
- data_in_0_valid, input, 1: activation beat valid.
- data_in_0_ready, output, 1: activation beat accepted.
- weight, input, [WEIGHT_PRECISION_0-1:0] x PARALLELISM: weight lanes.
- weight_valid, input, 1: weight beat valid.
- weight_ready, output, 1: weight beat accepted.
- data_out_0, output, [ACC_WIDTH-1:0]: dot-product result.
- data_out_0_valid, output, 1: result valid.
- data_out_0_ready, input, 1: downstream accepts result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=ACCUM, beat counter=0, accumulator=0.
  - data_out_0=0, data_out_0_valid=0.
  - Both ready outputs are 0 while rst is high.
- States:
  - ACCUM: gathering beats.
  - OUTPUT: result held on data_out_0.
- Join handshake:
  - can_take = (state==ACCUM) or (state==OUTPUT and data_out_0_ready).
  - data_in_0_ready = can_take & weight_valid.
  - weight_ready = can_take & data_in_0_valid.
  - fire = can_take & data_in_0_valid & weight_valid.
  - Both streams advance together on fire and never independently.
  - Ready is combinational from the other valid and data_out_0_ready. No combinational path from data to ready.
- Arithmetic:
  - Each product is signed, DATA_IN_0_PRECISION_0+WEIGHT_PRECISION_0 bits.
  - Lane sum is sign-extended to ACC_WIDTH.
  - Accumulation is two's complement and sized so no overflow is possible. No saturation, no rounding.
- On fire:
  - Counter is 0, or state is OUTPUT: acc <= lane_sum.
  - Otherwise: acc <= acc + lane_sum.
  - Counter increments and wraps from IN_DEPTH-1 to 0.
- Last beat (fire with counter==IN_DEPTH-1):
  - data_out_0 <= final sum (acc+lane_sum, or lane_sum when IN_DEPTH==1).
  - data_out_0_valid <= 1; state -> OUTPUT.
- Latency: data_out_0_valid rises one cycle after the last-beat fire.
- OUTPUT with data_out_0_ready=0:
  - data_out_0 and data_out_0_valid are held stable.
  - Both input readies are 0.
- OUTPUT with data_out_0_ready=1:
  - The result is consumed.
  - Without fire: valid -> 0, state -> ACCUM.
  - With fire: the new beat starts a fresh accumulation in the same cycle. Valid stays 1 only if that fire is also the last beat (IN_DEPTH==1), with the new result loaded.
- Throughput: one result every IN_DEPTH cycles under continuous valid/ready. No bubble between results.
- Reset mid-accumulation discards the partial sum and the counter. The next fire is beat 0.
- Input valid dropping mid-accumulation pauses the count. The partial sum is retained indefinitely.

Test Plan:
- Default parameters (P=4, DEPTH=4), continuous valids, data_out_0_ready=1. All activations raw 1 and all weights raw 2 for 4 beats -> data_out_0=32 with valid for exactly 1 cycle, one cycle after the 4th fire.
- Activations raw -3 and weights raw 5, all lanes, 4 beats -> data_out_0=-240, sign-extended to ACC_WIDTH=36 bits.
- Extreme values: all lanes -32768 x -32768 for 4 beats -> 2^34 (0x4_0000_0000) with no overflow. Then -32768 x 32767 -> -17179344896.
- Backpressure: hold data_out_0_ready=0 for 5 cycles after valid rises. Result is stable, both input readies are 0, and no beats are lost. Releasing ready with inputs valid starts the next accumulation that cycle.
- Join: weight_valid held 1, data_in_0_valid toggling every cycle. Only cycles with both valid count, and weight_ready mirrors data_in_0_valid. Beat pattern 1,2,3,4 (acts) x 1 (weights) -> 4*(1+2+3+4)=40.
- Reset asserted asynchronously after 2 beats, then 4 beats of raw 1x1 -> 16 (not 24). Back-to-back runs with ready=1 yield valid pulses every 4 cycles.
